// File: rtl/data_mux_arbiter.sv
// Round-robin arbiter/sequencer for the 4:1 register data mux: one owner per tenure, valid/ready
// load handshake, burst-bounded tenures. Define DATA_ARB_TIMEOUT_EN to add the stall watchdog.
module data_mux_arbiter #(
  parameter int unsigned MAX_BURST      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] last,
  input  logic       load_ready,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       load_valid,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned BeatW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StRelease
  } state_e;

  state_e           r_state, w_state_next;
  logic [1:0]       r_sel, w_sel_next;
  logic [1:0]       r_rr_ptr, w_rr_ptr_next;
  logic [BeatW-1:0] r_beat_cnt, w_beat_cnt_next;
  logic [1:0]       w_winner, w_scan;
  logic             w_found;
  logic             w_beat;
  logic             w_burst_hit;
  logic             w_timeout;

  if (MAX_BURST < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("data_mux_arbiter: MAX_BURST must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  // First requester after the last owner; 2-bit add wraps the scan modulo 4.
  always_comb begin
    w_winner = 2'd0;
    w_scan   = 2'd0;
    w_found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      w_scan = r_rr_ptr + 2'(i);
      if (!w_found && req[w_scan]) begin
        w_winner = w_scan;
        w_found  = 1'b1;
      end
    end
  end

  assign grant       = (r_state == StXfer) ? (4'b0001 << r_sel) : 4'b0000;
  assign sel         = r_sel;
  assign load_valid  = (r_state == StXfer) && req[r_sel];
  assign busy        = (r_state != StIdle);
  assign w_beat      = load_valid && load_ready;
  assign w_burst_hit = (r_beat_cnt == BeatW'(MAX_BURST - 1));

  always_comb begin
    w_state_next    = r_state;
    w_sel_next      = r_sel;
    w_rr_ptr_next   = r_rr_ptr;
    w_beat_cnt_next = r_beat_cnt;
    case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_next    = StXfer;
          w_sel_next      = w_winner;
          w_beat_cnt_next = '0;
        end
      end
      StXfer: begin
        if (!req[r_sel]) begin
          w_state_next = StRelease;
        end else if (w_beat) begin
          w_beat_cnt_next = r_beat_cnt + 1'b1;
          if (last[r_sel] || w_burst_hit) w_state_next = StRelease;
        end else if (w_timeout) begin
          w_state_next = StRelease;
        end
      end
      StRelease: begin
        // sel deliberately held so the mux does not glitch during the dead cycle.
        w_state_next    = StIdle;
        w_rr_ptr_next   = r_sel;
        w_beat_cnt_next = '0;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_sel      <= 2'd0;
      r_rr_ptr   <= 2'd3;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_sel      <= w_sel_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_beat_cnt <= w_beat_cnt_next;
    end
  end

`ifdef DATA_ARB_TIMEOUT_EN
  localparam int unsigned StallW = $clog2(TIMEOUT_CYCLES + 1);

  logic [StallW-1:0] r_stall_cnt;
  logic              r_timeout_err;

  // Fires on the stall cycle that brings the count to TIMEOUT_CYCLES; a beat always wins.
  assign w_timeout = (r_state == StXfer) && req[r_sel] && !w_beat &&
                     (r_stall_cnt == StallW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (r_state != StXfer || w_beat) begin
        r_stall_cnt <= '0;
      end else begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
